// File: rtl/tcb_dec.sv
// TCB address decoder: routes one manager's transfers to one of PN subordinate ports
// and returns responses through a DLY-deep pipeline; unmapped addresses are answered locally with an error.
module tcb_dec #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 32,
  parameter int unsigned BW  = DW/8,
  parameter int unsigned PN  = 2,
  parameter int unsigned DLY = 1,
  parameter logic [0:PN-1][AW-1:0] DAM = {PN{32'hF000_0000}},
  parameter logic [0:PN-1][AW-1:0] DAS = {32'h0000_0000, 32'h8000_0000}
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // manager side
  input  logic                   s_vld_i,
  input  logic                   s_wen_i,
  input  logic [AW-1:0]          s_adr_i,
  input  logic [BW-1:0]          s_ben_i,
  input  logic [DW-1:0]          s_wdt_i,
  output logic [DW-1:0]          s_rdt_o,
  output logic                   s_err_o,
  output logic                   s_rdy_o,
  // subordinate side: vld per port, request payload shared by all ports
  output logic [PN-1:0]          m_vld_o,
  output logic                   m_wen_o,
  output logic [AW-1:0]          m_adr_o,
  output logic [BW-1:0]          m_ben_o,
  output logic [DW-1:0]          m_wdt_o,
  input  logic [PN-1:0][DW-1:0]  m_rdt_i,
  input  logic [PN-1:0]          m_err_i,
  input  logic [PN-1:0]          m_rdy_i
);

  localparam int unsigned SW = (PN > 1) ? $clog2(PN) : 1;

  typedef struct packed {
    logic          ena;
    logic [SW-1:0] sel;
    logic          derr;
  } slot_t;

  logic [PN-1:0]    hit_s;
  logic [SW-1:0]    sel_s;
  logic             derr_s;
  logic             xfer_s;
  slot_t [DLY-1:0]  pipe_q;
  slot_t [DLY-1:0]  pipe_d;
  slot_t            last_s;

  // address decode, lowest matching port wins
  always_comb begin
    hit_s  = '0;
    sel_s  = '0;
    derr_s = 1'b1;
    for (int i = 0; i < PN; i++) begin
      hit_s[i] = ((s_adr_i & DAM[i]) == DAS[i]);
      sel_s    = (derr_s && hit_s[i]) ? SW'(i) : sel_s;
      derr_s   = (derr_s && hit_s[i]) ? 1'b0 : derr_s;
    end
  end

  // request routing and handshake
  always_comb begin
    for (int i = 0; i < PN; i++) begin
      m_vld_o[i] = s_vld_i & ~derr_s & (sel_s == SW'(i));
    end
    m_wen_o = s_wen_i;
    m_adr_o = s_adr_i;
    m_ben_o = s_ben_i;
    m_wdt_o = s_wdt_i;
    s_rdy_o = derr_s ? 1'b1 : m_rdy_i[sel_s];
    xfer_s  = s_vld_i & s_rdy_o;
  end

  // response pipeline next state: stage 0 captures the transfer, others shift
  always_comb begin
    pipe_d      = pipe_q;
    pipe_d[0]   = '{ena: xfer_s, sel: sel_s, derr: derr_s};
    for (int k = 1; k < DLY; k++) begin
      pipe_d[k] = pipe_q[k-1];
    end
  end

  // response pipeline registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign last_s = pipe_q[DLY-1];

  // response mux; an empty slot never looks at subordinate responses
  always_comb begin
    s_rdt_o = '0;
    s_err_o = 1'b0;
    case ({last_s.ena, last_s.derr})
      2'b10: begin
        s_rdt_o = m_rdt_i[last_s.sel];
        s_err_o = m_err_i[last_s.sel];
      end
      2'b11: begin
        s_rdt_o = '0;
        s_err_o = 1'b1;
      end
      default: begin
        s_rdt_o = '0;
        s_err_o = 1'b0;
      end
    endcase
  end

endmodule
